// File: rtl/ultrasonic_echo_if.sv
// ultrasonic_echo_if
//   Bundles the trigger/echo pins and the target programming inputs of the
//   ultrasonic echo responder. Clock and reset are not part of the bundle.
//
//   Signals:
//     trig           initiator -> responder, raw trigger pin (asynchronous)
//     distance_cm    initiator -> responder, programmed target distance in cm
//     target_valid   initiator -> responder, 1 = target present, 0 = no return
//     echo           responder -> initiator, echo pulse
//     busy           responder -> initiator, measurement in progress
//     err_short_trig responder -> initiator, one-cycle rejected-trigger pulse
//
//   Modports:
//     master  the side that drives trig and the target settings (driver/bench)
//     slave   the echo responder itself
interface ultrasonic_echo_if;
  logic       trig;
  logic [8:0] distance_cm;
  logic       target_valid;
  logic       echo;
  logic       busy;
  logic       err_short_trig;

  modport master (
    output trig,
    output distance_cm,
    output target_valid,
    input  echo,
    input  busy,
    input  err_short_trig
  );

  modport slave (
    input  trig,
    input  distance_cm,
    input  target_valid,
    output echo,
    output busy,
    output err_short_trig
  );
endinterface

// File: rtl/ultrasonic_echo_model.sv
// ultrasonic_echo_model
//   Stand-in for an ultrasonic range-finder module. It qualifies a trigger
//   pulse, waits out the acoustic burst, then drives an echo pulse whose width
//   encodes the programmed target distance, followed by a dead time.
//
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   ultrasonic_echo_if.slave: trig, distance_cm, target_valid in;
//           echo, busy, err_short_trig out
//
//   Optional feature:
//     ECHO_JITTER_EN  when defined, an 8-bit LFSR value is added to every echo
//                     width and the LFSR advances once per accepted trigger.
module ultrasonic_echo_model #(
  parameter int unsigned F_CLK           = 50_000_000,
  parameter int unsigned MIN_TRIG_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10_000,
  parameter int unsigned CYCLES_PER_CM   = 2900,
  parameter int unsigned MAX_ECHO_CYCLES = 1_900_000,
  parameter int unsigned HOLDOFF_CYCLES  = 500_000,
  parameter int unsigned MAX_CM          = 400
) (
  input logic               clk,
  input logic               rst,
  ultrasonic_echo_if.slave  bus
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Echo width register holds the largest width plus up to 255 cycles of jitter.
  localparam int WW = $clog2(MAX_ECHO_CYCLES + 256);
  // One shared counter covers trigger width, burst, echo and holdoff phases.
  localparam int CW = maxOf(maxOf(WW, $clog2(HOLDOFF_CYCLES + 1)),
                            maxOf($clog2(BURST_CYCLES + 1), $clog2(MIN_TRIG_CYCLES + 1)));

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG_HI = 3'd1;
  localparam logic [2:0] ST_BURST   = 3'd2;
  localparam logic [2:0] ST_ECHO    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Every phase must last at least one cycle and the clock must be real.
  if (F_CLK == 0 || MIN_TRIG_CYCLES == 0 || BURST_CYCLES == 0 || HOLDOFF_CYCLES == 0) begin : g_bad_params
    $error("ultrasonic_echo_model: timing parameters must be non-zero");
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] width_q, width_d;
  logic          echo_q, echo_d;
  logic          err_q, err_d;
  logic          sync1_q, trig_s_q;
  logic [1:0]    sync_ok_q;
  logic          prev_low_q;

  logic [8:0]    d_clamp;
  logic [WW-1:0] base_width;
  logic [WW-1:0] width_calc;

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_next;
  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

  // Target distance to echo width; distances below 2 cm read as 2 cm and a
  // missing or out-of-range target produces the no-return timeout width.
  always_comb begin
    d_clamp = (bus.distance_cm < 9'd2) ? 9'd2 : bus.distance_cm;
    if (!bus.target_valid || (32'(d_clamp) > MAX_CM)) begin
      base_width = WW'(MAX_ECHO_CYCLES);
    end else begin
      base_width = WW'(d_clamp) * WW'(CYCLES_PER_CM);
    end
`ifdef ECHO_JITTER_EN
    width_calc = base_width + WW'(lfsr_q);
`else
    width_calc = base_width;
`endif
  end

  // Next-state logic: one counter is reused in every phase and cleared on
  // each phase change, so a phase lasting N cycles ends when it reads N-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    echo_d  = echo_q;
    err_d   = 1'b0;
`ifdef ECHO_JITTER_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig_s_q && prev_low_q) begin
          state_d = ST_TRIG_HI;
          cnt_d   = CW'(1);
        end
      end
      ST_TRIG_HI: begin
        if (trig_s_q) begin
          if (cnt_q < CW'(MIN_TRIG_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q >= CW'(MIN_TRIG_CYCLES)) begin
          state_d = ST_BURST;
          cnt_d   = '0;
          width_d = width_calc;
`ifdef ECHO_JITTER_EN
          lfsr_d  = lfsr_next;
`endif
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_q == CW'(BURST_CYCLES - 1)) begin
          state_d = ST_ECHO;
          cnt_d   = '0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ECHO: begin
        if ((cnt_q + CW'(1)) == CW'(width_q)) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          echo_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
  end

  // Synchronizer plus a "previous sample was a genuine low" flag. sync_ok_q
  // marks when trig_s_q reflects the pin again after reset, so a trigger held
  // high through reset release never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      sync_ok_q  <= 2'b00;
      prev_low_q <= 1'b0;
    end else begin
      sync1_q    <= bus.trig;
      trig_s_q   <= sync1_q;
      sync_ok_q  <= {sync_ok_q[0], 1'b1};
      prev_low_q <= sync_ok_q[1] & ~trig_s_q;
    end
  end

  // Measurement state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ECHO_JITTER_EN
      lfsr_q  <= 8'hA5;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      err_q   <= err_d;
`ifdef ECHO_JITTER_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign bus.echo           = echo_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.err_short_trig = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// tb_ultrasonic_echo_model
//   Directed bench for ultrasonic_echo_model with shortened timing parameters.
//   Cycle numbers are taken from a free-running counter; outputs are sampled
//   on the falling clock edge.
module tb_ultrasonic_echo_model;

  localparam int MIN_TRIG = 5;
  localparam int BURST    = 10;
  localparam int CPC      = 3;
  localparam int MAX_ECHO = 1500;
  localparam int HOLDOFF  = 20;
  localparam int MAXCM    = 400;

  logic clk;
  logic rst;
  ultrasonic_echo_if bus();

  ultrasonic_echo_model #(
    .F_CLK(100_000_000),
    .MIN_TRIG_CYCLES(MIN_TRIG),
    .BURST_CYCLES(BURST),
    .CYCLES_PER_CM(CPC),
    .MAX_ECHO_CYCLES(MAX_ECHO),
    .HOLDOFF_CYCLES(HOLDOFF),
    .MAX_CM(MAXCM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event recorder: cycle numbers of the latest echo/busy edges, pulse counts.
  int riseCyc = -1, fallCyc = -1, busyRiseCyc = -1, busyFallCyc = -1, errCyc = -1;
  int riseCount = 0, errCount = 0;
  logic echoPrev = 1'b0, busyPrev = 1'b0;
  always @(negedge clk) begin
    if (bus.echo && !echoPrev) begin riseCyc = cyc; riseCount++; end
    if (!bus.echo && echoPrev) fallCyc = cyc;
    if (bus.busy && !busyPrev) busyRiseCyc = cyc;
    if (!bus.busy && busyPrev) busyFallCyc = cyc;
    if (bus.err_short_trig) begin errCount++; errCyc = cyc; end
    echoPrev = bus.echo;
    busyPrev = bus.busy;
  end

  int checksTotal = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    if (observed == expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  logic [7:0] lfsrModel = 8'hA5;

  // Expected echo width for one accepted trigger; advances the jitter model.
  task automatic nextWidth(input int d, input bit v, output int w);
    int dc;
    dc = (d < 2) ? 2 : d;
    w = (!v || dc > MAXCM) ? MAX_ECHO : dc * CPC;
`ifdef ECHO_JITTER_EN
    w = w + int'(lfsrModel);
    lfsrModel = {lfsrModel[6:0], lfsrModel[7] ^ lfsrModel[5] ^ lfsrModel[4] ^ lfsrModel[3]};
`endif
  endtask

  // Drive a trigger pulse of n cycles; returns the start cycle and cycle F.
  task automatic applyStimulus(input int n, output int startCyc, output int fCyc);
    @(negedge clk);
    bus.trig = 1'b1;
    startCyc = cyc;
    repeat (n) @(negedge clk);
    bus.trig = 1'b0;
    fCyc = cyc + 2;
  endtask

  task automatic waitIdle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk); #1;
      if (!bus.busy) done = 1'b1;
    end
    if (!done) checkOutput({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic waitEcho(input logic level, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk); #1;
      if (bus.echo == level) done = 1'b1;
    end
    if (!done) checkOutput({tag, "_echo_timeout"}, 1, 0);
  endtask

  task automatic runMeasurement(input int d, input bit v, input string tag);
    int s, f, w;
    bus.distance_cm  = 9'(d);
    bus.target_valid = v;
    applyStimulus(MIN_TRIG, s, f);
    nextWidth(d, v, w);
    repeat (4) @(negedge clk);
    bus.distance_cm  = 9'd7;
    bus.target_valid = ~v;
    waitIdle(tag);
    checkOutput({tag, "_busy_rise"}, busyRiseCyc, s + 3);
    checkOutput({tag, "_echo_rise"}, riseCyc, f + BURST + 1);
    checkOutput({tag, "_width"}, fallCyc - riseCyc, w);
    checkOutput({tag, "_busy_fall"}, busyFallCyc, fallCyc + HOLDOFF);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int s, f, w, r0, e0;
    rst = 1'b1;
    bus.trig = 1'b0;
    bus.distance_cm = 9'd0;
    bus.target_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_echo", int'(bus.echo), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_err", int'(bus.err_short_trig), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal and boundary distances, exact minimum trigger width.
    runMeasurement(100, 1'b1, "d100");
    runMeasurement(100, 1'b0, "novalid");
    runMeasurement(450, 1'b1, "d450");
    runMeasurement(0, 1'b1, "d0");
    runMeasurement(1, 1'b1, "d1");
    runMeasurement(2, 1'b1, "d2");
    runMeasurement(400, 1'b1, "d400");
    runMeasurement(401, 1'b1, "d401");

    // One cycle short of the minimum trigger width is rejected.
    e0 = errCount; r0 = riseCount;
    bus.distance_cm = 9'd100; bus.target_valid = 1'b1;
    applyStimulus(MIN_TRIG - 1, s, f);
    repeat (BURST + 20) @(negedge clk);
    #1;
    checkOutput("short_err_count", errCount - e0, 1);
    checkOutput("short_err_cycle", errCyc, f + 1);
    checkOutput("short_busy_fall", busyFallCyc, f + 1);
    checkOutput("short_no_echo", riseCount - r0, 0);

    // Triggers during ECHO and HOLDOFF are ignored.
    e0 = errCount; r0 = riseCount;
    applyStimulus(MIN_TRIG, s, f);
    nextWidth(100, 1'b1, w);
    waitEcho(1'b1, "retrig");
    repeat (20) @(negedge clk);
    bus.trig = 1'b1;
    repeat (MIN_TRIG + 3) @(negedge clk);
    bus.trig = 1'b0;
    waitEcho(1'b0, "retrig");
    bus.trig = 1'b1;
    repeat (MIN_TRIG) @(negedge clk);
    bus.trig = 1'b0;
    waitIdle("retrig");
    repeat (BURST + 30) @(negedge clk);
    #1;
    checkOutput("retrig_width", fallCyc - riseCyc, w);
    checkOutput("retrig_one_echo", riseCount - r0, 1);
    checkOutput("retrig_no_err", errCount - e0, 0);
    checkOutput("retrig_busy_fall", busyFallCyc, fallCyc + HOLDOFF);

    // Reset mid-ECHO with trig held high through release.
    applyStimulus(MIN_TRIG, s, f);
    nextWidth(100, 1'b1, w);
    waitEcho(1'b1, "rstmid");
    repeat (3) @(negedge clk);
    bus.trig = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_echo", int'(bus.echo), 0);
    checkOutput("rstmid_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    lfsrModel = 8'hA5;
    r0 = riseCount;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("rstmid_held_no_echo", riseCount - r0, 0);
    checkOutput("rstmid_held_no_busy", int'(bus.busy), 0);
    bus.trig = 1'b0;
    repeat (5) @(negedge clk);
    runMeasurement(10, 1'b1, "post_reset");
    runMeasurement(10, 1'b1, "post_reset2");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
